// File: rtl/ex_div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU beside the EX-stage ALU.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow go straight from IDLE to FIN.
module ex_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef DIV_FASTPATH_EN
    localparam bit FASTPATH = 1'b1;
`else
    localparam bit FASTPATH = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q, spv_q, result_q;
    logic             neg_q, rem_op_q, spc_q, done_q, busy_q;

    // Operand decode for the accept cycle: funct3[1] selects REM, funct3[0] selects unsigned.
    logic             sgn_c, sa_c, sb_c, accept_c, spc_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c, spv_c;

    always_comb begin
        sgn_c    = ~funct3[0];
        sa_c     = sgn_c & op_a[WIDTH-1];
        sb_c     = sgn_c & op_b[WIDTH-1];
        mag_a_c  = sa_c ? (~op_a + WIDTH'(1)) : op_a;
        mag_b_c  = sb_c ? (~op_b + WIDTH'(1)) : op_b;
        accept_c = (state_q == IDLE) & start & funct3[2] & ~flush;
        spc_c    = 1'b0;
        spv_c    = '0;
        if (op_b == '0) begin
            spc_c = 1'b1;
            spv_c = funct3[1] ? op_a : '1;
        end else if (sgn_c && (op_a == MIN_NEG) && (op_b == '1)) begin
            spc_c = 1'b1;
            spv_c = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step: shift {rem, quo} left and trial-subtract the divisor with a sign bit.
    logic [WIDTH:0]   rem_sh_c, diff_c;
    logic [WIDTH-1:0] rem_d, quo_d, fin_c;

    always_comb begin
        rem_sh_c = {rem_q, quo_q[WIDTH-1]};
        diff_c   = rem_sh_c - {1'b0, div_q};
        rem_d    = diff_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
        quo_d    = {quo_q[WIDTH-2:0], ~diff_c[WIDTH]};
        if (spc_q) begin
            fin_c = spv_q;
        end else if (rem_op_q) begin
            fin_c = neg_q ? (~rem_d + WIDTH'(1)) : rem_d;
        end else begin
            fin_c = neg_q ? (~quo_d + WIDTH'(1)) : quo_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            spv_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            rem_op_q <= 1'b0;
            spc_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept_c) begin
                            rem_op_q <= funct3[1];
                            neg_q    <= funct3[1] ? sa_c : (sa_c ^ sb_c);
                            quo_q    <= mag_a_c;
                            div_q    <= mag_b_c;
                            rem_q    <= '0;
                            cnt_q    <= '0;
                            spc_q    <= spc_c;
                            spv_q    <= spv_c;
                            busy_q   <= 1'b1;
                            if (FASTPATH && spc_c) begin
                                state_q  <= FIN;
                                result_q <= spv_c;
                                done_q   <= 1'b1;
                            end else begin
                                state_q <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            state_q  <= FIN;
                            result_q <= fin_c;
                            done_q   <= 1'b1;
                        end
                    end
                    FIN: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Stall is combinational so EX freezes in the accept cycle itself.
    assign stall  = accept_c | (state_q == CALC);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed self-checking bench for ex_div_seq (WIDTH=32); honours DIV_FASTPATH_EN for special-case latency.
module tb_ex_div_seq;
    localparam int unsigned W = 32;
`ifdef DIV_FASTPATH_EN
    localparam int SPC_LAT = 1;
`else
    localparam int SPC_LAT = 33;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   funct3 = 3'b000;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         stall, busy, done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    ex_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Issues one op at a negedge (cycle 0) and reports latency, result and stalled-cycle count.
    task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output logic [W-1:0] res, output int nstall);
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1;
        nstall = stall ? 1 : 0;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        res = 'x;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (done) begin
                lat = c;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_divu();
        int lat, ns;
        logic [W-1:0] res;
        run_op(3'b101, 32'd100, 32'd7, lat, res, ns);
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result: got %h want %h", res, 32'd14); end
        checks++; if (ns !== 33) begin errors++; $display("FAIL divu_stall_cycles: got %0d want 33", ns); end
        repeat (2) @(negedge clk);
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL divu_hold: got %h want %h", result, 32'd14); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL divu_idle: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_flush();
        int lat;
        logic seen_done;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        seen_done = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0 || seen_done !== 1'b0) begin errors++; $display("FAIL flush_done: got done=%b seen=%b want 0 0", done, seen_done); end
        checks++; if (result !== 32'd14) begin errors++; $display("FAIL flush_result: got %h want %h", result, 32'd14); end
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1000; op_b = 32'd3;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL flush_restart_stall: got %b want 1", stall); end
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
        checks++; if (lat !== 33) begin errors++; $display("FAIL flush_restart_latency: got %0d want 33", lat); end
        checks++; if (result !== 32'd333) begin errors++; $display("FAIL flush_restart_result: got %h want %h", result, 32'd333); end
    endtask

    task automatic test_signed();
        logic [2:0]   f[8]  = '{3'b110, 3'b100, 3'b100, 3'b110, 3'b100, 3'b111, 3'b101, 3'b110};
        logic [W-1:0] a[8]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        logic [W-1:0] b[8]  = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h10, 32'd1, 32'hFFFFFFFE};
        logic [W-1:0] e[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd1, 32'd4, 32'hF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        int lat, ns;
        logic [W-1:0] res;
        for (int i = 0; i < 8; i++) begin
            run_op(f[i], a[i], b[i], lat, res, ns);
            checks++;
            if (res !== e[i] || lat !== 33) begin
                errors++;
                $display("FAIL signed_vec%0d: got %h lat %0d want %h lat 33", i, res, lat, e[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [2:0]   f[4] = '{3'b100, 3'b111, 3'b110, 3'b101};
        logic [W-1:0] a[4] = '{32'd5, 32'd5, 32'hFFFFFFF9, 32'd0};
        logic [W-1:0] e[4] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFFF};
        int lat, ns;
        logic [W-1:0] res;
        for (int i = 0; i < 4; i++) begin
            run_op(f[i], a[i], 32'd0, lat, res, ns);
            checks++;
            if (res !== e[i] || lat !== SPC_LAT || ns !== SPC_LAT) begin
                errors++;
                $display("FAIL divzero_vec%0d: got %h lat %0d stall %0d want %h lat %0d stall %0d",
                         i, res, lat, ns, e[i], SPC_LAT, SPC_LAT);
            end
        end
    endtask

    task automatic test_overflow();
        int lat, ns;
        logic [W-1:0] res;
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, lat, res, ns);
        checks++; if (res !== 32'h80000000 || lat !== SPC_LAT) begin errors++; $display("FAIL ovf_div: got %h lat %0d want 80000000 lat %0d", res, lat, SPC_LAT); end
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, lat, res, ns);
        checks++; if (res !== 32'h0 || lat !== SPC_LAT) begin errors++; $display("FAIL ovf_rem: got %h lat %0d want 0 lat %0d", res, lat, SPC_LAT); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_accept_cycle: got %b want 0", busy); end
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_cycle1: got %b want 1", busy); end
            end
            if (c == 5) begin
                start = 1'b1; funct3 = 3'b100; op_a = 32'd9; op_b = 32'd3;
            end
            if (c == 6) start = 1'b0;
            if (done) begin lat = c; break; end
        end
        checks++; if (lat !== 33 || result !== 32'd14) begin errors++; $display("FAIL busy_ignore_start: got %h lat %0d want %h lat 33", result, lat, 32'd14); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_fin: got %b want 0", busy); end
    endtask

    task automatic test_async_reset();
        int lat, ns;
        logic [W-1:0] res;
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset_ctl: got busy=%b stall=%b done=%b want 0 0 0", busy, stall, done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL async_reset_result: got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b111, 32'd100, 32'd7, lat, res, ns);
        checks++; if (res !== 32'd2 || lat !== 33) begin errors++; $display("FAIL post_reset_op: got %h lat %0d want 2 lat 33", res, lat); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_flush();
        test_signed();
        test_div_zero();
        test_overflow();
        test_start_while_busy();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/ex_div_seq.md
# ex_div_seq

Iterative RV32M divide sequencer attached beside the EX-stage ALU. It accepts a DIV/DIVU/REM/REMU operation from EX and runs a radix-2 restoring shift-subtract divide, one quotient bit per cycle. While it runs it holds the pipeline via `stall`, then presents a registered result for one `done` cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  EX holds a valid divide op this cycle.
- `funct3`  in  3  op select: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
- `op_a`  in  WIDTH  dividend (EX `readData1`).
- `op_b`  in  WIDTH  divisor (EX `readData2`).
- `flush`  in  1  kill the in-flight op (branch/exception).
- `stall`  out  1  freeze IF/ID/EX this cycle.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  WIDTH  quotient or remainder.

## Operation
- States: IDLE, CALC, FIN. Reset puts the block in IDLE with `busy`=0, `done`=0 and `result`=0; iteration counter, remainder and quotient registers are also 0.
- IDLE with `start`=1 and `flush`=0: latch the op and both operand magnitudes, plus the signs for DIV/REM. DIVU/REMU treat operands as unsigned. Clear the remainder and counter, then go to CALC.
- CALC, each cycle: shift {rem, quo} left by 1 and trial-subtract the divisor from rem.
  - Result non-negative: keep the difference and set quo[0]=1.
  - Otherwise restore rem and set quo[0]=0.
  - Counter increments; after iteration WIDTH-1 go to FIN.
- Entering FIN, `result` is registered:
  - DIV/DIVU: quotient, negated if the operand signs differ (signed ops only).
  - REM/REMU: remainder, negated if the dividend is negative (signed ops only).
- FIN: `done`=1 for exactly one cycle, then IDLE. `result` holds its value until the next accepted `start`.
- Divide by zero (`op_b`=0), all ops and both builds:
  - DIV/DIVU quotient is all ones.
  - REM/REMU remainder equals `op_a` unmodified.
- Signed overflow (DIV, `op_a`=0x80000000, `op_b`=0xFFFFFFFF): quotient 0x80000000, REM result 0.
- `start` while `busy`=1 is ignored.
- `flush`=1 in any state: go to IDLE on the next edge.
  - No `done` pulse; `result` is unchanged.
  - `flush` and `start` in the same IDLE cycle: `flush` wins and the op is not accepted.
- `rst_n` low mid-operation: immediate return to reset values, without waiting for a clock.
- All arithmetic is WIDTH bits. The trial subtraction uses a WIDTH+1-bit difference, and the sign of that difference decides restore.

## Timing
- `stall` = (IDLE & `start` & ~`flush`) | CALC. This is combinational, so EX freezes in the accept cycle.
- `stall`=0 in FIN, so the pipeline advances in the same cycle `done`=1 and EX captures `result` then.
- Normal latency: `start` accepted in cycle t, CALC in cycles t+1..t+WIDTH, `done` in cycle t+WIDTH+1 (33 for WIDTH=32).
- `busy` is registered: it is 0 in the accept cycle and 1 from t+1 through the FIN cycle.
- Back-to-back: a new `start` is accepted in the cycle after FIN at the earliest.

## Configuration
- `DIV_FASTPATH_EN` defined: divide by zero and signed overflow skip CALC.
  - IDLE goes directly to FIN, with `result` loaded from the special-case value.
  - `done` in cycle t+1; `stall` is high only in cycle t.
- `DIV_FASTPATH_EN` undefined: every op takes the full WIDTH+1 latency.
  - Special cases still produce the values listed under Operation, selected when FIN is entered.

## Test plan
- DIVU 100/7: start in cycle 0 → `stall` high in cycles 0..32, `done`=1 and `result`=14 in cycle 33; `result` still 14 two cycles later.
- REM 0xFFFFFFF9 (-7) / 2 → `result`=0xFFFFFFFF (-1). DIV of the same operands → 0xFFFFFFFD (-3).
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5.
  - Fast-path build: `done` in cycle 1.
  - Default build: `done` in cycle 33.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- `flush` in cycle 10 of a DIVU → IDLE in cycle 11 with no `done` and `result` unchanged. A `start` in cycle 11 is accepted and completes normally.
- `rst_n` low in cycle 5 between clock edges → `busy`, `stall` and `done` go to 0 immediately and `result`=0. `start` pulsed while `busy` is ignored, with no effect on the running result.
